// File: rtl/ureg_pkg.sv
// Shared definitions for the universal register: operating modes and the
// shift-counter width helper.
package ureg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // The counter must hold the values 0 .. WIDTH-1 and also fit WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/universal_register_if.sv
// Control and status bundle for universal_register.
// The `par` member exists only when UREG_PARITY_EN is defined.
interface universal_register_if
    import ureg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = ureg_pkg::cnt_width(WIDTH)
);
    logic             sclr;
    logic             ce;
    mode_e            mode;
    logic [WIDTH-1:0] d;
    logic             sin_r;
    logic             sin_l;
    logic             oe;
    logic             so_r;
    logic             so_l;
    logic [CNT_W-1:0] cnt;
    logic             done;
`ifdef UREG_PARITY_EN
    logic             par;
`endif

    modport master (
        output sclr, ce, mode, d, sin_r, sin_l, oe,
`ifdef UREG_PARITY_EN
        input  par,
`endif
        input  so_r, so_l, cnt, done
    );

    modport slave (
        input  sclr, ce, mode, d, sin_r, sin_l, oe,
`ifdef UREG_PARITY_EN
        output par,
`endif
        output so_r, so_l, cnt, done
    );

endinterface

// File: rtl/ureg_shift_counter.sv
// Counts shifts modulo WIDTH and emits a registered one-cycle `done` pulse
// after every WIDTH-th shift. Loads and clears restart the count.
module ureg_shift_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = ureg_pkg::cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sclr,
    input  logic             load,
    input  logic             shift,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (sclr || load) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (shift) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                done <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/universal_register.sv
// WIDTH-bit universal register: hold / shift right / shift left / load, with
// serial outputs at both ends, a tri-state parallel output and a shift counter.
// Optional registered parity output enabled by defining UREG_PARITY_EN.
module universal_register
    import ureg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 clr,
    universal_register_if.slave  bus,
    // The tri-state bus stays a plain port so the high-Z driver sits at a module boundary.
    output wire  [WIDTH-1:0]     q
);

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_next;
    logic             shift;
    logic             load;

    assign shift = bus.ce && (bus.mode == MODE_SHR || bus.mode == MODE_SHL);
    assign load  = bus.ce && (bus.mode == MODE_LOAD);

    // NOTE: r_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        r_next = r;
        if (bus.sclr) begin
            r_next = '0;
        end else if (bus.ce) begin
            unique case (bus.mode)
                MODE_SHR:  r_next = {bus.sin_r, r[WIDTH-1:1]};
                MODE_SHL:  r_next = {r[WIDTH-2:0], bus.sin_l};
                MODE_LOAD: r_next = bus.d;
                default:   r_next = r;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r <= '0;
        end else begin
            r <= r_next;
        end
    end

    ureg_shift_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .clr   (clr),
        .sclr  (bus.sclr),
        .load  (load),
        .shift (shift),
        .cnt   (bus.cnt),
        .done  (bus.done)
    );

`ifdef UREG_PARITY_EN
    logic par_r;

    // Registering the parity of r_next keeps par aligned with r on every edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            par_r <= 1'b0;
        end else begin
            par_r <= ^r_next;
        end
    end

    assign bus.par = par_r;
`endif

    assign bus.so_r = r[0];
    assign bus.so_l = r[WIDTH-1];
    assign q        = bus.oe ? r : {WIDTH{1'bz}};

endmodule

// File: tb/tb_universal_register.sv
// Self-checking bench for universal_register (WIDTH=4): expected output
// snapshots are queued when stimulus is applied and compared after the edge.
module tb_universal_register;
    import ureg_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = cnt_width(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             so_r;
        logic             so_l;
        logic [CNT_W-1:0] cnt;
        logic             done;
    } obs_t;

    logic             clk;
    logic             clr;
    wire  [WIDTH-1:0] q;

    universal_register_if #(.WIDTH(WIDTH)) bus ();

    universal_register #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus),
        .q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    obs_t exp_o;
    obs_t obs_o;

    function automatic obs_t sample();
        return {q, bus.so_r, bus.so_l, bus.cnt, bus.done};
    endfunction

    // Expected snapshot with oe=1: serial outputs follow the register ends.
    task automatic push(input logic [WIDTH-1:0] qv, input int c, input logic dn);
        logic [WIDTH-1:0] v;
        v = qv;
        sb.push_back({v, v[0], v[WIDTH-1], CNT_W'(c), dn});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        bus.oe = 1'b1; bus.ce = 1'b0; bus.sclr = 1'b0; bus.mode = MODE_HOLD;
        bus.d = '0; bus.sin_r = 1'b0; bus.sin_l = 1'b0;
        #3;
        push(4'b0000, 0, 1'b0);
        exp_o = sb.pop_front(); obs_o = sample(); n_total++;
        if (obs_o !== exp_o) $display("FAIL reset_async: got %b want %b", obs_o, exp_o);
        else n_pass++;
        tick();
        tick();
        push(4'b0000, 0, 1'b0);
        exp_o = sb.pop_front(); obs_o = sample(); n_total++;
        if (obs_o !== exp_o) $display("FAIL reset_held: got %b want %b", obs_o, exp_o);
        else n_pass++;
        clr = 1'b1;
    endtask

    task automatic test_load();
        bus.ce = 1'b1; bus.mode = MODE_LOAD; bus.d = 4'b0011;
        push(4'b0011, 0, 1'b0);
        tick();
        exp_o = sb.pop_front(); obs_o = sample(); n_total++;
        if (obs_o !== exp_o) $display("FAIL load: got %b want %b", obs_o, exp_o);
        else n_pass++;
        bus.mode = MODE_HOLD;
    endtask

    task automatic test_oe();
        bus.oe = 1'b0;
        #1;
        sb.push_back({4'bzzzz, 1'b1, 1'b0, CNT_W'(0), 1'b0});
        exp_o = sb.pop_front(); obs_o = sample(); n_total++;
        if (obs_o !== exp_o) $display("FAIL oe_off: got %b want %b", obs_o, exp_o);
        else n_pass++;
        tick();
        sb.push_back({4'bzzzz, 1'b1, 1'b0, CNT_W'(0), 1'b0});
        exp_o = sb.pop_front(); obs_o = sample(); n_total++;
        if (obs_o !== exp_o) $display("FAIL oe_off_hold: got %b want %b", obs_o, exp_o);
        else n_pass++;
        bus.oe = 1'b1;
        #1;
        push(4'b0011, 0, 1'b0);
        exp_o = sb.pop_front(); obs_o = sample(); n_total++;
        if (obs_o !== exp_o) $display("FAIL oe_on: got %b want %b", obs_o, exp_o);
        else n_pass++;
    endtask

    task automatic test_shift_right();
        logic [WIDTH-1:0] exp_q [5] = '{4'b1001, 4'b1100, 4'b1110, 4'b1111, 4'b1111};
        int               exp_c [5] = '{1, 2, 3, 0, 1};
        bus.mode = MODE_LOAD; bus.d = 4'b0011;
        tick();
        bus.mode = MODE_SHR; bus.sin_r = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(exp_q[i], exp_c[i], i == 3);
            tick();
            exp_o = sb.pop_front(); obs_o = sample(); n_total++;
            if (obs_o !== exp_o) $display("FAIL shr[%0d]: got %b want %b", i, obs_o, exp_o);
            else n_pass++;
        end
        bus.mode = MODE_HOLD;
        push(4'b1111, 1, 1'b0);
        tick();
        exp_o = sb.pop_front(); obs_o = sample(); n_total++;
        if (obs_o !== exp_o) $display("FAIL shr_hold: got %b want %b", obs_o, exp_o);
        else n_pass++;
    endtask

    task automatic test_shift_left_ce();
        bus.mode = MODE_LOAD; bus.d = 4'b1010;
        tick();
        bus.mode = MODE_SHL; bus.sin_l = 1'b0;
        push(4'b0100, 1, 1'b0);
        tick();
        exp_o = sb.pop_front(); obs_o = sample(); n_total++;
        if (obs_o !== exp_o) $display("FAIL shl: got %b want %b", obs_o, exp_o);
        else n_pass++;
        bus.ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(4'b0100, 1, 1'b0);
            tick();
            exp_o = sb.pop_front(); obs_o = sample(); n_total++;
            if (obs_o !== exp_o) $display("FAIL ce_off[%0d]: got %b want %b", i, obs_o, exp_o);
            else n_pass++;
        end
        bus.ce = 1'b1; bus.mode = MODE_HOLD;
    endtask

    task automatic test_clears();
        logic [WIDTH-1:0] exp_q [3] = '{4'b1000, 4'b1100, 4'b1110};
        bus.mode = MODE_LOAD; bus.d = 4'b0001;
        tick();
        bus.mode = MODE_SHL; bus.sin_l = 1'b1;
        tick();
        tick();
        bus.sclr = 1'b1; bus.mode = MODE_LOAD; bus.d = 4'b1111;
        push(4'b0000, 0, 1'b0);
        tick();
        exp_o = sb.pop_front(); obs_o = sample(); n_total++;
        if (obs_o !== exp_o) $display("FAIL sclr: got %b want %b", obs_o, exp_o);
        else n_pass++;
        bus.sclr = 1'b0; bus.mode = MODE_SHR; bus.sin_r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(exp_q[i], i + 1, 1'b0);
            tick();
            exp_o = sb.pop_front(); obs_o = sample(); n_total++;
            if (obs_o !== exp_o) $display("FAIL pre_clr[%0d]: got %b want %b", i, obs_o, exp_o);
            else n_pass++;
        end
        clr = 1'b0;
        #2;
        push(4'b0000, 0, 1'b0);
        exp_o = sb.pop_front(); obs_o = sample(); n_total++;
        if (obs_o !== exp_o) $display("FAIL clr_async: got %b want %b", obs_o, exp_o);
        else n_pass++;
        clr = 1'b1;
        bus.mode = MODE_HOLD;
        push(4'b0000, 0, 1'b0);
        tick();
        exp_o = sb.pop_front(); obs_o = sample(); n_total++;
        if (obs_o !== exp_o) $display("FAIL clr_no_done: got %b want %b", obs_o, exp_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] r_m;
        logic             s;
        bus.mode = MODE_LOAD; bus.d = 4'b0110;
        tick();
        r_m = 4'b0110;
        for (int i = 0; i < 2 * WIDTH + 1; i++) begin
            s = 1'($urandom_range(0, 1));
            bus.sin_r = s; bus.sin_l = s;
            if (i % 2 == 0) begin
                bus.mode = MODE_SHR;
                r_m = {s, r_m[WIDTH-1:1]};
            end else begin
                bus.mode = MODE_SHL;
                r_m = {r_m[WIDTH-2:0], s};
            end
            push(r_m, (i + 1) % WIDTH, ((i + 1) % WIDTH) == 0);
            tick();
            exp_o = sb.pop_front(); obs_o = sample(); n_total++;
            if (obs_o !== exp_o) $display("FAIL mixed[%0d]: got %b want %b", i, obs_o, exp_o);
            else n_pass++;
        end
        bus.mode = MODE_HOLD;
    endtask

`ifdef UREG_PARITY_EN
    task automatic test_parity();
        bus.mode = MODE_LOAD; bus.d = 4'b0111;
        tick();
        n_total++;
        if (bus.par !== 1'b1 || q !== 4'b0111) $display("FAIL par_load: got par=%b q=%b want par=1 q=0111", bus.par, q);
        else n_pass++;
        bus.mode = MODE_SHR; bus.sin_r = 1'b0;
        tick();
        n_total++;
        if (bus.par !== 1'b0 || q !== 4'b0011) $display("FAIL par_shr: got par=%b q=%b want par=0 q=0011", bus.par, q);
        else n_pass++;
        bus.mode = MODE_LOAD; bus.d = 4'b0001;
        tick();
        clr = 1'b0;
        #2;
        n_total++;
        if (bus.par !== 1'b0) $display("FAIL par_reset: got par=%b want par=0", bus.par);
        else n_pass++;
        clr = 1'b1;
        bus.mode = MODE_HOLD;
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_oe();
        test_shift_right();
        test_shift_left_ce();
        test_clears();
        test_back_to_back();
`ifdef UREG_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
- Parametrised successor to the team's 4-bit clear/output-enable register.
- A WIDTH-bit universal register with four modes: hold, shift-right, shift-left and parallel load.
- Provides serial in/out at both ends, a tri-state parallel output and a shift counter that pulses `done` after every WIDTH shifts.
- Used as a parallel-to-serial / serial-to-parallel converter and as a general storage register in datapath experiments.

Parameters:
- WIDTH, default 4: register width in bits; legal range ≥ 2.
- CNT_W, default $clog2(WIDTH+1): shift counter width; derived, not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset; asynchronous, active-low; clears all state.
- sclr  in  1  synchronous clear, active-high.
- ce  in  1  clock enable, active-high.
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- d  in  WIDTH  parallel load data.
- sin_r  in  1  serial input entering the MSB on a right shift.
- sin_l  in  1  serial input entering the LSB on a left shift.
- oe  in  1  output enable, active-high.
- q  out  WIDTH  equals r when oe=1, high-Z when oe=0.
- so_r  out  1  serial out, equals r[0]; always driven.
- so_l  out  1  serial out, equals r[WIDTH-1]; always driven.
- cnt  out  CNT_W  number of shifts since the last load, clear or wrap.
- done  out  1  one-cycle pulse after the WIDTH-th shift.

Behaviour:
- Reset: clr=0 forces r=0, cnt=0, done=0 immediately, independent of clk. While clr=0, q=0 if oe=1 and high-Z if oe=0.
- Priority per edge: clr, then sclr, then ce, then mode.
- sclr=1: sets r=0, cnt=0, done=0. This applies regardless of ce and mode.
- ce=0: r and cnt hold; done=0.
- mode 00 (hold): r and cnt hold; done=0.
- mode 01 (shift right): r ← {sin_r, r[WIDTH-1:1]}.
- mode 10 (shift left): r ← {r[WIDTH-2:0], sin_l}.
- mode 11 (load): r ← d; cnt ← 0; done=0.
- Shift counting:
  - On each shift, if cnt == WIDTH-1 then cnt ← 0 and done ← 1; otherwise cnt ← cnt+1 and done ← 0.
  - done is registered and high exactly one cycle, the cycle after the WIDTH-th shift edge.
  - Back-to-back shifts wrap continuously, so done pulses every WIDTH shifts.
- Mixed directions: a direction change mid-sequence still counts; cnt counts shifts, not direction.
- Latency:
  - Load, shift and clear results are visible on q/so_* one edge later.
  - The oe effect on q is combinational, zero cycles.
- oe gates only q. Internal state, so_r, so_l, cnt and done are unaffected by oe.
- Reset released near a clock edge: no update occurs on the edge coincident with the clr rising edge. A reset synchroniser upstream is required.
- Reset mid-sequence: a partial shift count is discarded; no done pulse is emitted.

Optional Feature:
- UREG_PARITY_EN defined:
  - Adds output port `par` (1 bit), registered XOR-reduction of the next value of r, so it always equals ^r.
  - Reset value 0; unaffected by oe.
- Undefined: `par` port absent; no parity logic.

Decomposition:
- Package ureg_pkg:
  - MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
  - Function for CNT_W.
- Sub-module ureg_shift_counter (params WIDTH, CNT_W):
  - Inputs: clk, clr, sclr, load, shift.
  - Outputs: cnt, done.
  - Instantiated once; the top holds the data register, output mux and tri-state.

Test Plan (WIDTH=4):
1. Reset and load: clr=0 → q=0000, cnt=0, done=0. Then clr=1, ce=1, oe=1, mode=11, d=0011 → q=0011 after one edge.
2. Output enable: from r=0011, oe=0 → q=zzzz at once while so_r=1 and so_l=0; oe=1 → q=0011, proving state was retained.
3. Shift right and done: load 0011, then mode=01, sin_r=1 for 4 edges → q=1001, 1100, 1110, 1111 and cnt=1, 2, 3, 0. done is high only in the cycle after the 4th edge; a 5th shift gives cnt=1, done=0.
4. Shift left and ce: load 1010, mode=10, sin_l=0 → q=0100, so_l=0. Then ce=0 for 3 edges → q=0100, cnt=1 unchanged.
5. Clears mid-sequence: after 2 shifts, sclr=1 with mode=11 and d=1111 → q=0000, cnt=0. After 3 shifts, clr pulsed low between edges → q=0000 and cnt=0 immediately, with no done pulse.
6. Parity (UREG_PARITY_EN defined): load 0111 → par=1; shift right with sin_r=0 → q=0011, par=0; reset → par=0.
